// File: rtl/zjh_scan_pkg.sv
// rtl/zjh_scan_pkg.sv - state encoding and 7-segment constants shared by the scan controller files
package zjh_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Index is the nibble value; segment a sits in bit 6, g in bit 0.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

endpackage

// File: rtl/zjh_seg7_dec.sv
// rtl/zjh_seg7_dec.sv - combinational hex nibble to abcdefg segment decoder
module zjh_seg7_dec
    import zjh_scan_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/zjh_scan_ctrl.sv
// rtl/zjh_scan_ctrl.sv - time-multiplexed 7-segment scan controller with frame-synchronous buffer commit
// Optional leading-zero suppression is enabled by defining ZJH_SCAN_LZ_BLANK_EN.
module zjh_scan_ctrl
    import zjh_scan_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int PRESCALE  = 4,
    parameter int BLANK_CYC = 1
) (
    input  logic                Clk,
    input  logic                MR,
    input  logic                En,
    input  logic                Load,
    input  logic [4*DIGITS-1:0] Din,
    output logic [6:0]          Seg,
    output logic [DIGITS-1:0]   Dig,
    output logic                FrameDone,
    output logic                Busy
);

    localparam int MAXC = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                wrap;
    logic [4*DIGITS-1:0] active_q, active_d, pend_q, pend_d;
    logic                flag_q, flag_d;
    logic [6:0]          seg_q, dec_seg;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic                fd_q;
    logic [3:0]          nib;
    logic                suppress;
`ifdef ZJH_SCAN_LZ_BLANK_EN
    logic                lz_run;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap    = 1'b0;
        case (state_q)
            IDLE: begin
                idx_d = '0;
                cnt_d = '0;
                if (En) state_d = (BLANK_CYC == 0) ? SHOW : BLANK;
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = SHOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHOW: begin
                // En is only honoured here, so a lit digit always gets its full dwell.
                if (cnt_q == SHOW_LAST) begin
                    cnt_d = '0;
                    wrap  = (idx_q == IDX_LAST);
                    idx_d = (wrap || !En) ? '0 : idx_q + 1'b1;
                    if (!En)                 state_d = IDLE;
                    else if (BLANK_CYC == 0) state_d = SHOW;
                    else                     state_d = BLANK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pend_d   = pend_q;
        flag_d   = flag_q;
        active_d = active_q;
        if (Load) begin
            pend_d = Din;
            flag_d = 1'b1;
        end
        // A Load landing on a commit edge bypasses pending and goes live at once.
        if (wrap || state_q == IDLE) begin
            if (Load)        active_d = Din;
            else if (flag_q) active_d = pend_q;
            flag_d = 1'b0;
        end
    end

    always_comb begin
        nib   = 4'd0;
        dig_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IW'(i)) begin
                nib      = active_d[4*i +: 4];
                dig_d[i] = (state_d == SHOW);
            end
        end
    end

    always_comb begin
        suppress = 1'b0;
`ifdef ZJH_SCAN_LZ_BLANK_EN
        lz_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lz_run = lz_run && (active_d[4*i +: 4] == 4'd0);
            if (idx_d == IW'(i)) suppress = lz_run;
        end
`endif
    end

    zjh_seg7_dec u_dec (
        .nib_i (nib),
        .seg_o (dec_seg)
    );

    always_ff @(posedge Clk) begin
        if (!MR) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            active_q <= '0;
            pend_q   <= '0;
            flag_q   <= 1'b0;
            seg_q    <= SEG_OFF;
            dig_q    <= '0;
            fd_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            flag_q   <= flag_d;
            seg_q    <= (state_d == SHOW && !suppress) ? dec_seg : SEG_OFF;
            dig_q    <= dig_d;
            fd_q     <= wrap;
        end
    end

    assign Seg       = seg_q;
    assign Dig       = dig_q;
    assign FrameDone = fd_q;
    assign Busy      = (state_q != IDLE);

endmodule

// File: tb/tb_zjh_scan_ctrl.sv
// tb/tb_zjh_scan_ctrl.sv - self-checking bench for zjh_scan_ctrl (DIGITS=4, PRESCALE=4, BLANK_CYC=1)
module tb_zjh_scan_ctrl;

    localparam int PRESCALE = 4;

`ifdef ZJH_SCAN_LZ_BLANK_EN
    localparam logic [6:0] LZ0 = 7'b0000000;
`else
    localparam logic [6:0] LZ0 = 7'b1111110;
`endif

    typedef struct {
        logic [3:0] dig;
        logic [6:0] seg;
    } exp_t;

    typedef struct {
        logic [15:0]      din;
        logic [3:0][6:0]  seg;
    } vec_t;

    logic        Clk, MR, En, Load;
    logic [15:0] Din;
    logic [6:0]  Seg;
    logic [3:0]  Dig;
    logic        FrameDone, Busy;

    int   n_chk  = 0;
    int   n_fail = 0;
    bit   sb_on  = 0;
    exp_t sb_q[$];
    logic [6:0] hex_seg [16];
    vec_t vec [6];

    zjh_scan_ctrl #(.DIGITS(4), .PRESCALE(4), .BLANK_CYC(1)) dut (
        .Clk       (Clk),
        .MR        (MR),
        .En        (En),
        .Load      (Load),
        .Din       (Din),
        .Seg       (Seg),
        .Dig       (Dig),
        .FrameDone (FrameDone),
        .Busy      (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] din, input int ndig);
        exp_t e;
        for (int i = 0; i < ndig; i++) begin
            e.dig = 4'b0001 << i;
            e.seg = hex_seg[din[4*i +: 4]];
            sb_q.push_back(e);
        end
    endtask

    // Pops one expectation at the first cycle of every lit slot and measures its dwell.
    logic [3:0] prev_dig = 4'd0;
    int         run_len  = 0;
    bit         tracking = 0;
    always @(negedge Clk) begin
        exp_t e;
        if (!MR) begin
            prev_dig = 4'd0;
            tracking = 0;
        end else begin
            if (Dig != 4'd0) begin
                if (prev_dig == 4'd0 && sb_on) begin
                    if (sb_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL sb_underflow: slot with Dig=%b but no expectation queued", Dig);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_dig", 32'(Dig), 32'(e.dig));
                        check("sb_seg", 32'(Seg), 32'(e.seg));
                    end
                    run_len  = 1;
                    tracking = 1;
                end else if (tracking) begin
                    run_len++;
                end
            end else if (prev_dig != 4'd0 && tracking) begin
                check("sb_dwell", 32'(run_len), 32'(PRESCALE));
                tracking = 0;
            end
            prev_dig = Dig;
        end
    end

    initial begin
        hex_seg = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
        vec[0] = '{16'h3210, {7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110}};
        vec[1] = '{16'h7654, {7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011}};
        vec[2] = '{16'hBA98, {7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111}};
        vec[3] = '{16'hFEDC, {7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110}};
        vec[4] = '{16'h0070, {LZ0, LZ0, 7'b1110000, 7'b1111110}};
        vec[5] = '{16'h0000, {LZ0, LZ0, LZ0, 7'b1111110}};

        MR = 1'b0; En = 1'b0; Load = 1'b0; Din = 16'h0;
        tick();
        tick();
        check("reset_seg", 32'(Seg), 0);
        check("reset_dig", 32'(Dig), 0);
        check("reset_fd", 32'(FrameDone), 0);
        check("reset_busy", 32'(Busy), 0);

        // Run from IDLE with 4321, mid-frame FFFF load, then En dropped in digit 2 of frame 3.
        MR = 1'b1; En = 1'b1; Load = 1'b1; Din = 16'h4321;
        push_frame(16'h4321, 4);
        push_frame(16'h4321, 4);
        sb_on = 1;
        tick();
        Load = 1'b0;
        check("t1_first_blank", 32'(Dig), 0);
        check("t1_busy", 32'(Busy), 1);
        for (int t = 1; t <= 58; t++) begin
            tick();
            case (t)
                1:  check("t1_dig0_seg", 32'(Seg), 32'(7'b0110000));
                5:  check("t1_gap", 32'(Dig), 0);
                19: check("t1_fd_early", 32'(FrameDone), 0);
                20: check("t1_fd", 32'(FrameDone), 1);
                21: check("t1_fd_pulse", 32'(FrameDone), 0);
                40: check("t2_fd", 32'(FrameDone), 1);
                54: check("t3_last_show", 32'(Dig), 32'(4'b0100));
                55: begin
                    check("t3_idle_dig", 32'(Dig), 0);
                    check("t3_idle_busy", 32'(Busy), 0);
                    check("t3_no_fd", 32'(FrameDone), 0);
                end
                57: check("t3_no_fd_late", 32'(FrameDone), 0);
                default: ;
            endcase
            Load = (t == 27);
            if (t == 27) begin
                Din = 16'hFFFF;
                push_frame(16'hFFFF, 3);
            end
            if (t == 52) En = 1'b0;
        end

        // Decode table: each record loaded from IDLE, one frame, En dropped in the last digit.
        foreach (vec[k]) begin
            exp_t e;
            En = 1'b1; Load = 1'b1; Din = vec[k].din;
            for (int i = 0; i < 4; i++) begin
                e.dig = 4'b0001 << i;
                e.seg = vec[k].seg[i];
                sb_q.push_back(e);
            end
            for (int t = 0; t <= 20; t++) begin
                tick();
                Load = 1'b0;
                if (t == 17) En = 1'b0;
            end
            check("tab_fd", 32'(FrameDone), 1);
            check("tab_idle", 32'(Busy), 0);
        end
        check("sb_drain", 32'(sb_q.size()), 0);
        sb_on = 0;

        // Reset during digit 3, then Load coincident with the wrap edge.
        En = 1'b1; Load = 1'b1; Din = 16'hFFFF;
        tick();
        Load = 1'b0;
        for (int t = 1; t <= 17; t++) tick();
        check("t4_pre_dig", 32'(Dig), 32'(4'b1000));
        check("t4_pre_seg", 32'(Seg), 32'(7'b1000111));
        MR = 1'b0;
        tick();
        check("t4_rst_seg", 32'(Seg), 0);
        check("t4_rst_dig", 32'(Dig), 0);
        check("t4_rst_fd", 32'(FrameDone), 0);
        check("t4_rst_busy", 32'(Busy), 0);
        MR = 1'b1; En = 1'b1;
        tick();
        for (int t = 1; t <= 31; t++) begin
            tick();
            case (t)
                1:  begin
                    check("t4_restart_dig", 32'(Dig), 32'(4'b0001));
                    check("t4_restart_seg", 32'(Seg), 32'(7'b1111110));
                end
                20: check("t5_wrap_fd", 32'(FrameDone), 1);
                21: check("t5_dig0_seg", 32'(Seg), 32'(7'b1111110));
                26: begin
                    check("t5_dig1_dig", 32'(Dig), 32'(4'b0010));
                    check("t5_dig1_seg", 32'(Seg), 32'(7'b1110111));
                end
                31: check("t5_dig2_seg", 32'(Seg), 32'(LZ0));
                default: ;
            endcase
            Load = (t == 19);
            if (t == 19) Din = 16'h00A0;
        end
        En = 1'b0;
        for (int t = 0; t < 8; t++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
